// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- sequential restoring divider (unsigned)
//
// Divides a DW-bit dividend by a VW-bit divisor, resolving one quotient bit per
// clock, MSB first. One operation goes through a start/busy/done handshake:
//   IDLE : waiting for start
//   RUN  : DW iteration steps, busy=1
//   FIN  : one cycle, done=1 with quotient/remainder valid
// A start seen in IDLE or FIN is accepted; in FIN this gives back-to-back
// operation with no idle cycle. A start seen in RUN is dropped.
//
// Parameters
//   DW : dividend / quotient width (default 8)
//   VW : divisor / remainder width (default 4)
//
// Ports
//   clk          in   system clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset; aborts any operation
//   start        in   request a division (accepted only while busy=0)
//   dividend     in   DW   numerator, captured on the accepting edge
//   divisor      in   VW   denominator, captured on the accepting edge
//   quotient     out  DW   registered result, changes only on entry to FIN
//   remainder    out  VW   registered result, changes only on entry to FIN
//   busy         out  high while iterating
//   done         out  one-cycle pulse when results become valid
//   div_by_zero  out  high with done when the captured divisor was 0
//
// Build option
//   DIV_ZERO_CHECK_EN : when defined, a zero divisor skips the iterations and
//   finishes one cycle after acceptance with quotient=all ones, remainder=0
//   and div_by_zero=1. When undefined, div_by_zero stays 0 and a zero divisor
//   runs the normal iterations (quotient=all ones, remainder=dividend[VW-1:0]).
// -----------------------------------------------------------------------------
module div_seq #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  localparam int            CW        = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  // Working register shared between the dividend and the quotient: each step
  // shifts out the next dividend bit at the top and shifts the new quotient
  // bit in at the bottom, so after DW steps it holds the full quotient.
  logic [DW-1:0] work_reg;
  logic [VW-1:0] dvs_reg;
  // Partial remainder. It is always < divisor after a step, so VW bits are
  // enough to store it; only the shifted trial value needs VW+1 bits.
  logic [VW-1:0] part_reg;

  logic [VW:0]   shifted_next;
  logic          qbit_next;
  logic [VW-1:0] part_next;
  logic          zero_skip;

  // One restoring step: bring down the next dividend bit, then subtract the
  // divisor if it fits.
  always_comb begin
    shifted_next = {part_reg, work_reg[DW-1]};
    qbit_next    = (shifted_next >= {1'b0, dvs_reg});
    part_next    = shifted_next[VW-1:0];
    if (qbit_next) begin
      part_next = VW'(shifted_next - {1'b0, dvs_reg});
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  assign zero_skip = (dvs_reg == '0);
`else
  assign zero_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      work_reg    <= '0;
      dvs_reg     <= '0;
      part_reg    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (zero_skip) begin
            // Zero divisor detected on the first RUN cycle: finish early.
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_reg   <= FIN;
          end else begin
            part_reg  <= part_next;
            work_reg  <= {work_reg[DW-2:0], qbit_next};
            count_reg <= count_reg + CW'(1);
            if (count_reg == LAST_STEP) begin
              // Last step: publish results straight from the step logic so
              // done lines up with the DW-th iteration edge.
              quotient  <= {work_reg[DW-2:0], qbit_next};
              remainder <= part_next;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= FIN;
            end
          end
        end

        default: begin
          // IDLE and FIN both accept a new request; done and div_by_zero
          // fall here, which makes them single-cycle pulses.
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          if (start) begin
            work_reg  <= dividend;
            dvs_reg   <= divisor;
            part_reg  <= '0;
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq -- self-checking bench for div_seq (DW=8, VW=4)
//
// A behavioural model tracks, per clock edge, which operation is in flight and
// when its result is due (acceptance edge + latency), computing the result with
// plain / and %. A compare process checks every DUT output against the model on
// each falling edge. Directed operations additionally check hand-computed
// quotient, remainder, latency and busy-cycle counts.
// -----------------------------------------------------------------------------
module tb_div_seq;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  div_seq #(.DW(DW), .VW(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  // ---------------------------------------------------------------- model --
  int            edge_no  = 0;
  bit            m_active = 1'b0;
  int            m_due    = 0;
  logic [DW-1:0] m_q;
  logic [VW-1:0] m_r;
  logic          m_dbz;
  logic [DW-1:0] exp_q    = '0;
  logic [VW-1:0] exp_r    = '0;
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  logic          exp_dbz  = 1'b0;

  always @(posedge clk) begin
    bit nb, nd, ndbz, accept;
    int lat;
    edge_no = edge_no + 1;
    if (rst) begin
      m_active = 1'b0;
      exp_q    = '0;
      exp_r    = '0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_dbz  = 1'b0;
    end else begin
      accept = start && !exp_busy;
      nb = 1'b0; nd = 1'b0; ndbz = 1'b0;
      if (m_active) begin
        if (edge_no == m_due) begin
          exp_q    = m_q;
          exp_r    = m_r;
          nd       = 1'b1;
          ndbz     = m_dbz;
          m_active = 1'b0;
        end else begin
          nb = 1'b1;
        end
      end
      if (accept) begin
        lat = DW;
        if (divisor == '0) begin
          m_q   = '1;
          m_r   = ZCHK ? '0 : dividend[VW-1:0];
          m_dbz = ZCHK;
          if (ZCHK) lat = 1;
        end else begin
          m_q   = dividend / DW'(divisor);
          m_r   = VW'(dividend % DW'(divisor));
          m_dbz = 1'b0;
        end
        m_active = 1'b1;
        m_due    = edge_no + lat;
        nb       = 1'b1;
      end
      exp_busy = nb;
      exp_done = nd;
      exp_dbz  = ndbz;
    end
  end

  // -------------------------------------------------------------- compare --
  always @(negedge clk) begin
    if (check_en) begin
      tests++;
      if ({busy, done, div_by_zero, quotient, remainder} !==
          {exp_busy, exp_done, exp_dbz, exp_q, exp_r}) begin
        fails++;
        $display("FAIL cycle_check edge %0d: got busy=%b done=%b dbz=%b q=%0d r=%0d, expected busy=%b done=%b dbz=%b q=%0d r=%0d",
                 edge_no, busy, done, div_by_zero, quotient, remainder,
                 exp_busy, exp_done, exp_dbz, exp_q, exp_r);
      end
    end
  end

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Wait (from a falling edge) until done is high; returns edges waited.
  task automatic wait_done(output int waited, output int busy_cnt, input string tag);
    waited   = 0;
    busy_cnt = 0;
    while (!done && waited < 40) begin
      busy_cnt += int'(busy);
      @(negedge clk);
      waited++;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input int eq, input int er, input int edbz,
                        input int elat, input int ebusy, input string tag);
    int waited, busy_cnt;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(waited, busy_cnt, tag);
    chk({tag, "_lat"}, waited, elat);
    chk({tag, "_busy"}, busy_cnt, ebusy);
    chk({tag, "_q"}, int'(quotient), eq);
    chk({tag, "_r"}, int'(remainder), er);
    chk({tag, "_dbz"}, int'(div_by_zero), edbz);
    $display("[TB] op %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, quotient, remainder,
             div_by_zero, waited + 1);
  endtask

  // -------------------------------------------------------------- stimulus --
  initial begin
    int waited, busy_cnt, dones;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    chk("reset_q", int'(quotient), 0);
    chk("reset_r", int'(remainder), 0);
    chk("reset_busy_done", int'({busy, done, div_by_zero}), 0);
    rst = 1'b0;

    run_op(8'd200, 4'd7, 28, 4, 0, DW, DW, "200_7");

    // Back-to-back: start held through RUN and FIN.
    @(negedge clk);
    dividend = 8'd255; divisor = 4'd15; start = 1'b1;
    @(negedge clk);
    wait_done(waited, busy_cnt, "b2b1");
    chk("b2b1_lat", waited, DW);
    chk("b2b1_q", int'(quotient), 17);
    chk("b2b1_r", int'(remainder), 0);
    $display("[TB] op 255/15 -> q=%0d r=%0d lat=%0d", quotient, remainder, waited + 1);
    dividend = 8'd5; divisor = 4'd9;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap_busy", int'(busy), 1);
    chk("b2b_single_done", int'(done), 0);
    wait_done(waited, busy_cnt, "b2b2");
    chk("b2b2_lat", waited, DW);
    chk("b2b2_q", int'(quotient), 0);
    chk("b2b2_r", int'(remainder), 5);
    $display("[TB] op 5/9 -> q=%0d r=%0d lat=%0d", quotient, remainder, waited + 1);

    // Mid-RUN start pulse and operand toggling must be ignored.
    @(negedge clk);
    dividend = 8'd0; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!done && waited < 40) begin
      if (waited == 3) begin start = 1'b1; dividend = 8'hFF; divisor = 4'd1; end
      if (waited == 4) begin start = 1'b0; dividend = 8'hA5; divisor = 4'd6; end
      @(negedge clk);
      waited++;
    end
    chk("midrun_lat", waited, DW);
    chk("midrun_q", int'(quotient), 0);
    chk("midrun_r", int'(remainder), 0);
    $display("[TB] op 0/3 (perturbed) -> q=%0d r=%0d lat=%0d", quotient, remainder, waited + 1);

    if (ZCHK) run_op(8'd100, 4'd0, 255, 0, 1, 1, 1, "100_0");
    else      run_op(8'd100, 4'd0, 255, 4, 0, DW, DW, "100_0");

    // Reset 3 cycles into RUN of 200/7.
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_flags", int'({busy, done, div_by_zero}), 0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      dones += int'(done);
    end
    chk("abort_no_done", dones, 0);
    $display("[TB] op 200/7 aborted by reset");
    run_op(8'd200, 4'd7, 28, 4, 0, DW, DW, "200_7_again");

    // Exhaustive sweep of nonzero divisors.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(DW'(a), VW'(b), a / b, a % b, 0, DW, DW, "sweep");
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
